// File: rtl/rv_instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: opcodes, funct3 codes
// that change the I-type layout, and the loader FSM state type.
package rv_instr_encoder_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // Shift-immediate funct3 codes carry funct7 in the upper imm field
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SRXI  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FULL
  } enc_state_t;

  function automatic logic is_shift_imm(input logic [2:0] funct3);
    return (funct3 == F3_SLLI) || (funct3 == F3_SRXI);
  endfunction

endpackage

// File: rtl/rv_instr_encoder_if.sv
// Field-level instruction input channel plus the IMEM write port of the encoder.
interface rv_instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        op;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, op, funct3, funct7b5, rd, rs1, rs2, imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, op, funct3, funct7b5, rd, rs1, rs2, imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/rv_instr_encoder_pack.sv
// Combinational packing of instruction fields into an RV32I word, flagging
// unknown opcodes and odd branch/jump offsets as illegal.
module rv_instr_encoder_pack
  import rv_instr_encoder_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Immediate bits above the widest (J) format are simply dropped
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:21];

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_R:    word = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, op};
      OP_I: begin
        if (is_shift_imm(funct3))
          word = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, op};
        else
          word = {imm[11:0], rs1, funct3, rd, op};
      end
      OP_LOAD: word = {imm[11:0], rs1, funct3, rd, op};
      OP_S:    word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      OP_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        illegal = imm[0];
      end
      OP_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        illegal = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// Loads IMEM sequentially from field-level instruction descriptions; holds the
// session FSM, word count and the registered IMEM write port.
module rv_instr_encoder
  import rv_instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  rv_instr_encoder_if.slave bus,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  enc_state_t        state;
  logic              in_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic [31:0]       word;
  logic              illegal;
  logic              accept;
  logic [ADDR_W:0]   count_inc;

  rv_instr_encoder_pack u_pack (
    .op       (bus.op),
    .funct3   (bus.funct3),
    .funct7b5 (bus.funct7b5),
    .rd       (bus.rd),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .imm      (bus.imm),
    .word     (word),
    .illegal  (illegal)
  );

  assign accept    = bus.in_valid & in_ready_q & (state == ST_RUN);
  assign count_inc = count + 1'b1;

  // A beat offered in the same cycle as start/stop is not taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      count        <= '0;
      full         <= 1'b0;
      err          <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      if (start) begin
        state      <= ST_RUN;
        in_ready_q <= 1'b1;
        count      <= '0;
        full       <= 1'b0;
        err        <= 1'b0;
      end else if (stop) begin
        state      <= ST_IDLE;
        in_ready_q <= 1'b0;
      end else if (accept) begin
        if (illegal) begin
          err <= 1'b1;
        end else begin
          imem_we_q    <= 1'b1;
          imem_addr_q  <= count[ADDR_W-1:0];
          imem_wdata_q <= word;
          count        <= count_inc;
          if (count_inc == DEPTH) begin
            state      <= ST_FULL;
            full       <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;

endmodule
